// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, fetch FSM states and the fetch buffer entry.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } lc3b_fetch_state;

    localparam lc3b_word LC3B_INSTR_BYTES = 16'd2;

    typedef struct packed {
        lc3b_word instr;
        lc3b_word pc;
    } lc3b_fetch_entry;

endpackage

// File: rtl/lc3b_fetch_unit_if.sv
// Instruction-memory read port plus decode handshake and redirect for the fetch unit.
interface lc3b_fetch_unit_if;
    import lc3b_types::*;

    lc3b_word mem_address;
    logic     mem_read;
    logic     mem_resp;
    lc3b_word mem_rdata;
    logic     redirect;
    lc3b_word redirect_pc;
    lc3b_word instr;
    lc3b_word instr_pc;
    logic     instr_valid;
    logic     instr_ready;

    modport master (
        output mem_address, mem_read, instr, instr_pc, instr_valid,
        input  mem_resp, mem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_address, mem_read, instr, instr_pc, instr_valid,
        output mem_resp, mem_rdata, redirect, redirect_pc, instr_ready
    );

endinterface

// File: rtl/lc3b_fetch_fifo.sv
// Instruction buffer between fetch and decode; DEPTH must be a power of two so pointers wrap naturally.
module lc3b_fetch_fifo
    import lc3b_types::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  lc3b_fetch_entry wdata,
    output logic [CNT_W-1:0] count,
    output lc3b_fetch_entry head
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lc3b_fetch_entry  mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointers and occupancy; flush only rewinds pointers, stale data is never observed as valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{instr: 16'h0000, pc: 16'h0000};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/lc3b_fetch_unit.sv
// LC-3b instruction fetch: owns fetch_pc, drives the imem read port, buffers words for decode.
// Optional build macro LC3B_FETCH_ALIGN_CHECK_EN adds the fetch_misaligned flag and odd-target stall.
module lc3b_fetch_unit
    import lc3b_types::*;
#(
    parameter int       DEPTH    = 2,
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    lc3b_fetch_unit_if.master  bus
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
    ,
    output logic               fetch_misaligned
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    lc3b_fetch_state  state_r, state_s;
    lc3b_word         fetch_pc_r, fetch_pc_s;
    lc3b_word         mem_addr_r;
    logic             mem_read_r;
    logic             misaligned_r, misaligned_s;
    lc3b_word         load_pc_s;
    logic             push_s, pop_s;
    logic [CNT_W-1:0] count_s, post_cnt_s;
    lc3b_fetch_entry  head_s, wdata_s;

    lc3b_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (bus.redirect),
        .wdata (wdata_s),
        .count (count_s),
        .head  (head_s)
    );

    // Handshake, occupancy after this cycle, and the next fetch_pc.
    always_comb begin
        pop_s   = (count_s != {CNT_W{1'b0}}) & bus.instr_ready & ~bus.redirect;
        push_s  = (state_r == REQ) & bus.mem_resp & ~bus.redirect;
        wdata_s = '{instr: bus.mem_rdata, pc: fetch_pc_r + LC3B_INSTR_BYTES};
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
        load_pc_s    = bus.redirect_pc;
        misaligned_s = bus.redirect ? bus.redirect_pc[0] : misaligned_r;
`else
        load_pc_s    = bus.redirect_pc & 16'hFFFE;
        misaligned_s = 1'b0;
`endif
        if (bus.redirect) begin
            post_cnt_s = {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   post_cnt_s = count_s + CNT_ONE;
                2'b01:   post_cnt_s = count_s - CNT_ONE;
                default: post_cnt_s = count_s;
            endcase
        end
        if (bus.redirect) begin
            fetch_pc_s = load_pc_s;
        end else if (push_s) begin
            fetch_pc_s = fetch_pc_r + LC3B_INSTR_BYTES;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end
    end

    // Next-state logic; DROP waits out a request that a redirect made stale, since it cannot be aborted.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!misaligned_s && (bus.redirect || (count_s < DEPTH_C))) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (bus.redirect && !bus.mem_resp) begin
                    state_s = DROP;
                end else if (bus.mem_resp) begin
                    state_s = (!misaligned_s && (post_cnt_s < DEPTH_C)) ? REQ : IDLE;
                end else begin
                    state_s = REQ;
                end
            end
            DROP: begin
                if (bus.mem_resp) begin
                    state_s = misaligned_s ? IDLE : REQ;
                end else begin
                    state_s = DROP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, fetch PC and the registered memory request; the address only changes when a new request starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            fetch_pc_r   <= RESET_PC;
            mem_addr_r   <= RESET_PC;
            mem_read_r   <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            fetch_pc_r   <= fetch_pc_s;
            mem_read_r   <= (state_s != IDLE);
            misaligned_r <= misaligned_s;
            if (state_s == REQ) begin
                mem_addr_r <= fetch_pc_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

    assign bus.mem_address = mem_addr_r;
    assign bus.mem_read    = mem_read_r;
    assign bus.instr       = head_s.instr;
    assign bus.instr_pc    = head_s.pc;
    assign bus.instr_valid = (count_s != {CNT_W{1'b0}});
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
    assign fetch_misaligned = misaligned_r;
`endif

endmodule

// File: tb/tb_lc3b_fetch_unit.sv
// Scoreboard bench for lc3b_fetch_unit: a memory model with programmable latency feeds expected entries.
module tb_lc3b_fetch_unit;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset;
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
    logic fetch_misaligned;
`endif

    lc3b_fetch_unit_if bus();

    lc3b_fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    lc3b_fetch_entry exp_q[$];
    lc3b_word exp_pc, req_addr, redir_pc_ctl, redir_on_resp_pc;
    int  lat = 1;
    int  age = 0;
    int  resp_cnt = 0;
    bit  stale = 1'b0;
    bit  expect_valid = 1'b0;
    bit  ready_ctl = 1'b0;
    bit  redir_req = 1'b0;
    bit  redir_on_resp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic lc3b_word mem_word(input lc3b_word a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic lc3b_word target_of(input lc3b_word pc);
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
        return pc;
`else
        return pc & 16'hFFFE;
`endif
    endfunction

    // One clock: sample outputs after the edge, run memory model and scoreboard, drive inputs.
    task automatic step();
        bit       resp, rd, rdy;
        lc3b_word rpc;
        lc3b_fetch_entry e;
        @(posedge clk);
        #1;
        resp = 1'b0;
        if (bus.mem_read) begin
            if (age == 0) req_addr = bus.mem_address;
            else check_eq("addr_hold", bus.mem_address, req_addr);
            resp = (age >= lat);
            age  = resp ? 0 : age + 1;
        end else begin
            age = 0;
        end
        rd  = redir_req;
        rpc = redir_pc_ctl;
        rdy = ready_ctl;
        redir_req = 1'b0;
        if (resp && redir_on_resp) begin
            rd  = 1'b1;
            rpc = redir_on_resp_pc;
            rdy = 1'b1;
            redir_on_resp = 1'b0;
        end
        if (expect_valid) check_eq("valid_lat", bus.instr_valid, 1'b1);
        expect_valid = 1'b0;
        if (bus.instr_valid && rdy && !rd) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("instr", bus.instr, e.instr);
                check_eq("instr_pc", bus.instr_pc, e.pc);
            end
        end
        if (resp) begin
            if (stale) begin
                stale = 1'b0;
            end else if (!rd) begin
                check_eq("fetch_addr", req_addr, exp_pc);
                exp_q.push_back('{instr: mem_word(exp_pc), pc: exp_pc + 16'd2});
                exp_pc = exp_pc + 16'd2;
                resp_cnt++;
                expect_valid = 1'b1;
            end
        end
        if (rd) begin
            exp_q.delete();
            exp_pc = target_of(rpc);
            if (bus.mem_read && !resp) stale = 1'b1;
        end
        bus.mem_resp    = resp;
        bus.mem_rdata   = resp ? mem_word(bus.mem_address) : 16'h0000;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_redirect(input lc3b_word pc);
        redir_req    = 1'b1;
        redir_pc_ctl = pc;
        step();
        resp_cnt = 0;
    endtask

    task automatic wait_resp(input string tag, input int target);
        int n = 0;
        while (resp_cnt < target && n < 200) begin
            step();
            n++;
        end
        if (resp_cnt < target) check_eq(tag, resp_cnt, target);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.instr_ready = 1'b0;
        exp_pc = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mem_read", bus.mem_read, 1'b0);
        check_eq("rst_mem_address", bus.mem_address, 16'h0000);
        check_eq("rst_instr_valid", bus.instr_valid, 1'b0);
        check_eq("rst_instr", bus.instr, 16'h0000);
        check_eq("rst_instr_pc", bus.instr_pc, 16'h0000);
`ifdef LC3B_FETCH_ALIGN_CHECK_EN
        check_eq("rst_misaligned", fetch_misaligned, 1'b0);
`endif
        reset = 1'b0;

        // Streaming from reset: 0000, 0002, 0004 with instr_pc one ahead.
        ready_ctl = 1'b1;
        lat = 1;
        wait_resp("to_stream", 3);
        run(4);

        // Decode stalled: exactly two reads fill the buffer, then fetch idles.
        ready_ctl = 1'b0;
        do_redirect(16'h0000);
        run(20);
        check_eq("full_reads", resp_cnt, 2);
        check_eq("full_mem_read", bus.mem_read, 1'b0);
        check_eq("full_valid", bus.instr_valid, 1'b1);
        ready_ctl = 1'b1;
        wait_resp("to_resume", 4);

        // Redirect while a slow read is outstanding: stale word dropped, restart at 3000.
        lat = 3;
        n = 0;
        while (!(bus.mem_read && age == 1) && n < 50) begin
            step();
            n++;
        end
        check_eq("mid_req_reached", bus.mem_read && (age == 1), 1'b1);
        do_redirect(16'h3000);
        n = 0;
        while (!bus.instr_valid && n < 50) begin
            step();
            n++;
        end
        check_eq("redir_first_pc", bus.instr_pc, 16'h3002);
        wait_resp("to_redir", 3);

        // Redirect on the same cycle as a response and a ready pop: buffer empties, no pop.
        lat = 1;
        ready_ctl = 1'b0;
        do_redirect(16'h5000);
        wait_resp("to_fill1", 1);
        redir_on_resp = 1'b1;
        redir_on_resp_pc = 16'h6000;
        n = 0;
        while (redir_on_resp && n < 50) begin
            step();
            n++;
        end
        check_eq("hook_fired", redir_on_resp, 1'b0);
        step();
        check_eq("flush_empty", bus.instr_valid, 1'b0);
        check_eq("flush_next_addr", bus.mem_address, 16'h6000);
        ready_ctl = 1'b1;
        resp_cnt = 0;
        wait_resp("to_after_flush", 2);

        // Fetch PC wraps from FFFE to 0000.
        do_redirect(16'hFFFE);
        wait_resp("to_wrap", 3);
        run(3);

`ifdef LC3B_FETCH_ALIGN_CHECK_EN
        // Odd target stalls fetch until an even redirect clears the flag.
        do_redirect(16'h1001);
        run(10);
        check_eq("mis_flag_set", fetch_misaligned, 1'b1);
        check_eq("mis_no_read", bus.mem_read, 1'b0);
        check_eq("mis_no_resp", resp_cnt, 0);
        do_redirect(16'h1000);
        step();
        check_eq("mis_flag_clr", fetch_misaligned, 1'b0);
        wait_resp("to_mis_fetch", 2);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
